// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin arbiter and write-side mux for the shared serial bus.
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SEL_WIDTH      = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] breq,
    output logic [NUM_MASTERS-1:0] bgrant,
    input  logic [NUM_MASTERS-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0] m_mode,
    input  logic [NUM_MASTERS-1:0] m_mvalid,
    output logic                   bus_wdata,
    output logic                   bus_mode,
    output logic                   bus_mvalid,
    output logic [SEL_WIDTH-1:0]   msel,
    output logic                   bus_busy,
    output logic                   timeout
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_MAX = c_CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] bgrant_q;
    logic [SEL_WIDTH-1:0]   msel_q;
    logic [SEL_WIDTH-1:0]   last_q;
    logic [c_CNT_W-1:0]     hold_q;
    logic                   timeout_q;

    logic                   w_win_any;
    logic [SEL_WIDTH-1:0]   w_win_idx;

    assign w_win_any = |breq;

    // Scan downward so the last hit is the first requester after last_q.
    always_comb begin
        w_win_idx = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (breq[(int'(last_q) + k) % NUM_MASTERS]) begin
                w_win_idx = SEL_WIDTH'((int'(last_q) + k) % NUM_MASTERS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            bgrant_q  <= '0;
            msel_q    <= '0;
            last_q    <= SEL_WIDTH'(NUM_MASTERS - 1);
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_GRANT: begin
                    if (!breq[msel_q]) begin
                        state_q  <= ST_RELEASE;
                        bgrant_q <= '0;
                    end else if ((TIMEOUT_CYCLES != 0) && (hold_q != c_HOLD_MAX)) begin
                        // Counter saturates, so the pulse fires only once per grant.
                        hold_q <= hold_q + 1'b1;
                        if (hold_q == c_HOLD_MAX - 1'b1) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_win_any) begin
                        state_q  <= ST_GRANT;
                        bgrant_q <= NUM_MASTERS'(1) << w_win_idx;
                        msel_q   <= w_win_idx;
                        last_q   <= w_win_idx;
                        hold_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bgrant     = bgrant_q;
    assign msel       = msel_q;
    assign timeout    = timeout_q;
    assign bus_busy   = (state_q == ST_GRANT);
    assign bus_wdata  = bus_busy & m_wdata[msel_q];
    assign bus_mode   = bus_busy & m_mode[msel_q];
    assign bus_mvalid = bus_busy & m_mvalid[msel_q];

endmodule
`default_nettype wire
